// File: rtl/pacman_video_pkg.sv
// Shared video constants for the Pac-Man compositor: palette, RGB field widths
// and the default background/sprite pipeline depth.
// Latency: n/a (package). Backpressure: n/a.
// Contents: PAL_SIZE, R_W/G_W/B_W, BG_LAT_DEFAULT, rgb_t, pix_ctl_t, pal_lookup().
package pacman_video_pkg;

  localparam int PAL_SIZE       = 16;
  localparam int PAL_IDX_W      = $clog2(PAL_SIZE);
  localparam int R_W            = 3;
  localparam int G_W            = 3;
  localparam int B_W            = 2;
  localparam int RGB_W          = R_W + G_W + B_W;
  localparam int BG_LAT_DEFAULT = 2;
  localparam int X_W            = 10;
  localparam int Y_W            = 9;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb_t;

  // Timing-generator side-band that travels alongside each pixel.
  typedef struct packed {
    logic           hsync;
    logic           vsync;
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_ctl_t;

  // Entries 0-7: background effects layer; 8-15: sprite/maze layer.
  // Entry 12 is frightened-ghost blue, entry 15 is the white flash colour.
  function automatic rgb_t pal_lookup(input logic [PAL_IDX_W-1:0] idx);
    logic [RGB_W-1:0] v;
    case (idx)
      4'd0:    v = 8'h00;
      4'd1:    v = 8'hE0;
      4'd2:    v = 8'h1C;
      4'd3:    v = 8'h03;
      4'd4:    v = 8'hFC;
      4'd5:    v = 8'hE3;
      4'd6:    v = 8'h1F;
      4'd7:    v = 8'h92;
      4'd8:    v = 8'h49;
      4'd9:    v = 8'hF4;
      4'd10:   v = 8'hFE;
      4'd11:   v = 8'hF6;
      4'd12:   v = 8'h0B;
      4'd13:   v = 8'h9F;
      4'd14:   v = 8'hB6;
      default: v = 8'hFF;
    endcase
    return rgb_t'(v);
  endfunction

endpackage

// File: rtl/pixel_delay_line.sv
// Pixel-strobe gated shift register used to align side-band with late colour data.
// Latency: DEPTH pix_en strobes. Backpressure: none; pix_en low freezes every stage.
// Ports: clk, rst_n, pix_en, d[WIDTH] -> q[WIDTH]; stages reset to RST_VAL.
module pixel_delay_line
  import pacman_video_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (pix_en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Final video compositor: merges background and sprite layers through the palette.
// Latency: BG_LAT+1 pix_en strobes from x_in to outputs. Backpressure: none; pix_en low holds all state.
// Ports: clk, rst_n, pix_en, x_in/y_in/hsync_in/vsync_in/active_in, bg_color, fg_color, fright
//        -> vga_r/g/b, hsync_out, vsync_out, x_out, y_out, frame_count.
// Option: define FRIGHT_FLASH_EN to flash frightened ghosts white in the second half of each 16-frame period.
module pixel_compositor
  import pacman_video_pkg::*;
#(
  parameter int BG_LAT          = BG_LAT_DEFAULT, // 1..4
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic           active_in,
  input  logic [2:0]     bg_color,
  input  logic [3:0]     fg_color,
  input  logic           fright,
  output logic [R_W-1:0] vga_r,
  output logic [G_W-1:0] vga_g,
  output logic [B_W-1:0] vga_b,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [5:0]     frame_count
);

  localparam logic     SYNC_OFF = SYNC_ACTIVE_LOW;
  localparam pix_ctl_t CTL_RST  = '{hsync: SYNC_OFF, vsync: SYNC_OFF, active: 1'b0, x: '0, y: '0};

  pix_ctl_t ctl_in, ctl_dly;
  assign ctl_in = '{hsync: hsync_in, vsync: vsync_in, active: active_in, x: x_in, y: y_in};

  pixel_delay_line #(
    .WIDTH  ($bits(pix_ctl_t)),
    .DEPTH  (BG_LAT),
    .RST_VAL(CTL_RST)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .pix_en(pix_en),
    .d     (ctl_in),
    .q     (ctl_dly)
  );

  // Frame start is the strobe on which raw vsync goes inactive -> asserted.
  // vs_prev resets to "not asserted" so a vsync held asserted through reset
  // still counts as one frame start on release.
  logic vs_asserted, vs_prev, frame_start;
  assign vs_asserted = (vsync_in != SYNC_OFF);
  assign frame_start = pix_en & vs_asserted & ~vs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev     <= 1'b0;
      frame_count <= '0;
    end else if (pix_en) begin
      vs_prev <= vs_asserted;
      if (frame_start) frame_count <= frame_count + 6'd1;
    end
  end

  logic [2:0] fg_idx;
`ifdef FRIGHT_FLASH_EN
  // fright is only honoured at frame boundaries so the flash never tears mid-frame.
  logic fright_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           fright_q <= 1'b0;
    else if (frame_start) fright_q <= fright;
  end

  always_comb begin
    fg_idx = fg_color[2:0];
    if (fright_q && frame_count[3] && (fg_color[2:0] == 3'd4)) fg_idx = 3'd7;
  end
`else
  logic unused_fright;
  assign unused_fright = fright;
  assign fg_idx        = fg_color[2:0];
`endif

  rgb_t pix_rgb;
  always_comb begin
    pix_rgb = '0;
    if (!ctl_dly.active)  pix_rgb = '0;
    else if (fg_color[3]) pix_rgb = pal_lookup({1'b1, fg_idx});
    else                  pix_rgb = pal_lookup({1'b0, bg_color});
  end

  rgb_t rgb_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q     <= '0;
      hsync_out <= SYNC_OFF;
      vsync_out <= SYNC_OFF;
      x_out     <= '0;
      y_out     <= '0;
    end else if (pix_en) begin
      rgb_q     <= pix_rgb;
      hsync_out <= ctl_dly.hsync;
      vsync_out <= ctl_dly.vsync;
      x_out     <= ctl_dly.x;
      y_out     <= ctl_dly.y;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor (BG_LAT=2, active-low syncs).
// Latency: n/a. Backpressure: n/a.
// Random and directed stimulus compared against a queue-based reference model.
module tb_pixel_compositor;

  localparam int   BG_LAT = 2;
  localparam logic OFF    = 1'b1;  // deasserted sync level
  localparam logic ON     = 1'b0;  // asserted sync level

  logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
  logic       hsync_in = OFF, vsync_in = OFF, active_in = 1'b0, fright = 1'b0;
  logic [9:0] x_in = '0;
  logic [8:0] y_in = '0;
  logic [2:0] bg_color = '0;
  logic [3:0] fg_color = '0;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;
  logic       hsync_out, vsync_out;
  logic [9:0] x_out;
  logic [8:0] y_out;
  logic [5:0] frame_count;

  pixel_compositor #(.BG_LAT(BG_LAT), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x_in(x_in), .y_in(y_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
    .bg_color(bg_color), .fg_color(fg_color), .fright(fright),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .x_out(x_out), .y_out(y_out), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  logic [7:0] pal [16] = '{8'h00, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'h92,
                           8'h49, 8'hF4, 8'hFE, 8'hF6, 8'h0B, 8'h9F, 8'hB6, 8'hFF};

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic       hs, vs, act;
    logic [9:0] x;
    logic [8:0] y;
  } ctl_t;

  ctl_t       hist[$];
  int         fc;
  bit         vs_prev;
`ifdef FRIGHT_FLASH_EN
  bit         fq;
`endif
  logic [7:0] e_rgb;
  logic       e_hs, e_vs;
  logic [9:0] e_x;
  logic [8:0] e_y;

  task automatic model_reset();
    ctl_t idle;
    idle = '{OFF, OFF, 1'b0, 10'd0, 9'd0};
    hist.delete();
    repeat (BG_LAT) hist.push_back(idle);
    fc = 0; vs_prev = 1'b0;
`ifdef FRIGHT_FLASH_EN
    fq = 1'b0;
`endif
    e_rgb = 8'h00; e_hs = OFF; e_vs = OFF; e_x = '0; e_y = '0;
  endtask

  // Called once per accepted strobe, with the inputs present at that edge.
  task automatic model_strobe();
    ctl_t c, d;
    int   idx;
    bit   vs_now;
    c = '{hsync_in, vsync_in, active_in, x_in, y_in};
    hist.push_back(c);
    d = hist.pop_front();
    if (!d.act) e_rgb = 8'h00;
    else if (fg_color[3]) begin
      idx = 8 + int'(fg_color[2:0]);
`ifdef FRIGHT_FLASH_EN
      if (fq && ((fc / 8) % 2 == 1) && fg_color[2:0] == 3'd4) idx = 15;
`endif
      e_rgb = pal[idx];
    end else e_rgb = pal[bg_color];
    e_hs = d.hs; e_vs = d.vs; e_x = d.x; e_y = d.y;
    vs_now = (vsync_in == ON);
    if (vs_now && !vs_prev) begin
      fc = (fc + 1) % 64;
`ifdef FRIGHT_FLASH_EN
      fq = fright;
`endif
    end
    vs_prev = vs_now;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    if (rst_n && pix_en) model_strobe();
    @(negedge clk);
    chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);
    chk("sync", {hsync_out, vsync_out}, {e_hs, e_vs});
    chk("xy", {x_out, y_out}, {e_x, e_y});
    chk("frame_count", frame_count, fc[5:0]);
  endtask

  task automatic drv(input bit en, input bit hs, input bit vs, input bit act,
                     input int x, input int y, input int bg, input int fg, input bit fr);
    pix_en = en; hsync_in = hs; vsync_in = vs; active_in = act;
    x_in = x[9:0]; y_in = y[8:0]; bg_color = bg[2:0]; fg_color = fg[3:0]; fright = fr;
    step();
  endtask

  task automatic rand_run(input int n, input int period);
    bit en;
    for (int i = 0; i < n; i++) begin
      en = (period == 0) ? 1'($urandom_range(0, 1)) : (i % period == 0);
      if ($urandom_range(0, 40) == 0) fright = ~fright;
      drv(en, ($urandom_range(0, 9) == 0) ? ON : OFF, ($urandom_range(0, 15) == 0) ? ON : OFF,
          1'($urandom_range(0, 3) != 0), $urandom_range(0, 1023), $urandom_range(0, 511),
          $urandom_range(0, 7), $urandom_range(0, 15), fright);
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 8'h00);
    chk("rst_sync", {hsync_out, vsync_out}, 2'b11);
    chk("rst_xy", {x_out, y_out}, 19'd0);
    chk("rst_fc", frame_count, 6'd0);
    model_reset();
    drv(1, OFF, ON, 1, 5, 5, 1, 9, 0);  // strobes under reset are ignored
    drv(1, OFF, OFF, 1, 6, 6, 2, 9, 0);
    rst_n = 1'b1;
  endtask

  task automatic hold(input bit act, input int bg, input int fg, input bit fr);
    repeat (BG_LAT + 1) drv(1, OFF, OFF, act, 40, 20, bg, fg, fr);
  endtask

  task automatic vs_pulse(input bit fr);
    drv(1, OFF, ON, 0, 0, 0, 0, 0, fr);
    drv(1, OFF, OFF, 0, 0, 0, 0, 0, fr);
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;

    // Latency: x=100 active, its bg=3 arrives two strobes later.
    drv(1, OFF, OFF, 1, 100, 7, 0, 0, 0);
    drv(1, OFF, OFF, 0, 0, 0, 0, 0, 0);
    drv(1, OFF, OFF, 0, 0, 0, 3, 0, 0);
    chk("lat_x", x_out, 10'd100);
    chk("lat_rgb", {vga_r, vga_g, vga_b}, pal[3]);

    // Layer priority.
    hold(1, 5, 4'b1010, 0);
    chk("prio_fg", {vga_r, vga_g, vga_b}, pal[10]);
    hold(1, 5, 4'b0010, 0);
    chk("prio_bg", {vga_r, vga_g, vga_b}, pal[5]);
    hold(0, 5, 4'b1010, 0);
    chk("prio_blank", {vga_r, vga_g, vga_b}, 8'h00);

    rand_run(300, 1);
    rand_run(300, 4);
    rand_run(300, 0);

    do_reset();
    rand_run(200, 1);

    // Frame counter wrap.
    do_reset();
    repeat (63) vs_pulse(0);
    chk("fc_63", frame_count, 6'd63);
    vs_pulse(0);
    chk("fc_wrap", frame_count, 6'd0);

    // Frightened flash: fright sampled at frame start, fright dropped mid-frame.
    do_reset();
    repeat (8) vs_pulse(1);
    chk("fc_8", frame_count, 6'd8);
    hold(1, 2, 4'b1100, 0);
`ifdef FRIGHT_FLASH_EN
    chk("flash_on", {vga_r, vga_g, vga_b}, pal[15]);
`else
    chk("flash_on", {vga_r, vga_g, vga_b}, pal[12]);
`endif
    vs_pulse(0);
    hold(1, 2, 4'b1100, 1);
    chk("flash_cleared", {vga_r, vga_g, vga_b}, pal[12]);
    do_reset();
    repeat (7) vs_pulse(1);
    hold(1, 2, 4'b1100, 1);
    chk("flash_fc7", {vga_r, vga_g, vga_b}, pal[12]);

    rand_run(300, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 The block SHALL have parameter BG_LAT, default 2, meaning the clk-enabled pixel delay of bg_color/fg_color relative to x_in/y_in (range 1..4).
REQ-002 The block SHALL have parameter SYNC_ACTIVE_LOW, default 1, meaning hsync_in/vsync_in asserted level is 0.
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: pix_en  in  1  pixel strobe; all pipeline stages advance only when high.
REQ-006 Port: x_in  in  10  and  y_in  in  9  current pixel coordinates from the timing generator.
REQ-007 Port: hsync_in, vsync_in, active_in  in  1 each  raw sync and visible-area flags, aligned with x_in.
REQ-008 Port: bg_color  in  3  background effects color index, valid BG_LAT strobes after its x_in.
REQ-009 Port: fg_color  in  4  sprite/maze layer; bit3 = opaque, bits[2:0] = index; same alignment as bg_color.
REQ-010 Port: fright  in  1  ghost-frightened mode flag, sampled at frame start.
REQ-011 Port: vga_r  out  3,  vga_g  out  3,  vga_b  out  2  registered RGB.
REQ-012 Port: hsync_out, vsync_out  out  1 each  registered syncs; x_out  out  10,  y_out  out  9  delayed coordinates.
REQ-013 Port: frame_count  out  6  free-running frame counter.

Function
REQ-014 Sync/active/x/y SHALL pass through a BG_LAT-deep shift register advancing on pix_en, so they align with bg_color/fg_color.
REQ-015 Composite selection SHALL be: delayed active=0 -> black; else fg_color[3]=1 -> palette[8+fg_color[2:0]]; else palette[bg_color].
REQ-016 Palette SHALL be a 16-entry constant table of 8-bit RRRGGGBB values; entry 0 = 8'h00.
REQ-017 RGB, syncs, x_out, y_out SHALL be registered once more, giving total latency BG_LAT+1 pix_en strobes from x_in to output.
REQ-018 While pix_en=0 every pipeline register and output SHALL hold its value.
REQ-019 frame_count SHALL increment (wrap 63->0) on the pix_en strobe where vsync_in transitions inactive->asserted.
REQ-020 fright SHALL be latched into fright_q on that same strobe; mid-frame changes SHALL have no effect until the next frame.
REQ-021 Simultaneous vsync edge and reset SHALL give reset priority.

Reset
REQ-022 On rst_n=0 all outputs SHALL go immediately to: RGB 0, x_out/y_out 0, frame_count 0, hsync_out/vsync_out deasserted level (1 when SYNC_ACTIVE_LOW=1).
REQ-023 Delay-line sync stages SHALL reset to deasserted, active stages to 0; fright_q to 0.
REQ-024 Reset mid-line SHALL resume correct output BG_LAT+1 strobes after release, with no spurious sync pulse.

Configuration
REQ-025 Macro FRIGHT_FLASH_EN, when defined, SHALL remap opaque fg index 4 (frightened ghost blue) to index 7 (white) whenever fright_q=1 and frame_count[3]=1.
REQ-026 Without FRIGHT_FLASH_EN, fg indices SHALL pass unmodified and fright/fright_q logic SHALL be absent (port kept, ignored).

Structure
REQ-027 Palette table, palette size, RGB field widths and BG_LAT default SHALL live in shared package pacman_video_pkg.
REQ-028 The delay line SHALL be a sub-module pixel_delay_line (parameterised width and depth, pix_en-gated).

Verification
REQ-029 Reset: assert rst_n=0 mid-frame -> RGB=0, hsync_out=vsync_out=1, frame_count=0 immediately.
REQ-030 Latency: BG_LAT=2, pix_en every cycle, x_in=100 active, bg_color=3 two cycles later -> x_out=100 and RGB=palette[3] on cycle 3.
REQ-031 Priority: fg_color=4'b1010, bg_color=5 -> RGB=palette[10]; fg_color=4'b0010 -> palette[5]; active_in=0 -> 8'h00.
REQ-032 pix_en every 4th cycle -> outputs change only on strobe cycles, latency 3 strobes.
REQ-033 Drive 64 vsync pulses -> frame_count wraps to 0; fright toggled mid-frame -> fright_q changes only at next vsync edge.
REQ-034 FRIGHT_FLASH_EN defined, fright=1, frame_count=8, fg_color=4'b1100 -> RGB=palette[15]; frame_count=7 -> palette[12].
